// File: rtl/display_pkg.sv
// ============================================================================
// Module      : display_pkg
// Description : Shared widths and default sizing for the display FIFO slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    localparam int c_display_in_w   = 16;
    localparam int c_display_data_w = 8;
    localparam int c_display_depth  = 4;

endpackage : display_pkg

`default_nettype wire

// File: rtl/display_fifo_mem.sv
// ============================================================================
// Module      : display_fifo_mem
// Description : DEPTH x DATA_W storage, one write port, async read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_fifo_mem
    import display_pkg::*;
#(
    parameter int DATA_W = c_display_data_w,
    parameter int DEPTH  = c_display_depth
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : display_fifo_mem

`default_nettype wire

// File: rtl/display_fifo.sv
// ============================================================================
// Module      : display_fifo
// Description : First-word-fall-through CPU-to-display character buffer.
//               Optional sticky overflow flag under DISPLAY_FIFO_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_fifo
    import display_pkg::*;
#(
    parameter int DATA_W = c_display_data_w,
    parameter int DEPTH  = c_display_depth
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_en,
    input  logic [c_display_in_w-1:0]  in,
    output logic                       in_full,
    output logic [DATA_W-1:0]          out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef DISPLAY_FIFO_OVF_EN
    ,
    output logic                       ovf,
    input  logic                       ovf_clr
`endif
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH+1);

    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_cw-1:0]   r_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_unused_in;

    // Occupancy decides full/empty; pointers alike mean either state.
    assign w_full  = (r_count == c_cw'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && out_ready;
    assign w_push  = in_en && (!w_full || w_pop);

    // Upper bits of the CPU word are not stored.
    assign w_unused_in = ^in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    display_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data (in[DATA_W-1:0]),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    assign in_full   = w_full;
    assign out_valid = !w_empty;
    assign out       = w_empty ? '0 : w_rd_data;
    assign count     = r_count;

`ifdef DISPLAY_FIFO_OVF_EN
    logic w_drop;
    logic r_ovf;

    assign w_drop = in_en && w_full && !w_pop;

    // A drop in the same cycle as a clear wins, so no loss goes unreported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule : display_fifo

`default_nettype wire

// File: tb/tb_display_fifo.sv
// ============================================================================
// Module      : tb_display_fifo
// Description : Directed + random scoreboard bench for display_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_en;
    logic [15:0]       din;
    logic              in_full;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        count;
    logic              ovf_clr;
`ifdef DISPLAY_FIFO_OVF_EN
    logic              ovf;
`endif

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] sb[$];
    logic              exp_ovf  = 1'b0;

    always #5 clk = ~clk;

    display_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_en     (in_en),
        .in        (din),
        .in_full   (in_full),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
`ifdef DISPLAY_FIFO_OVF_EN
        ,
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [DATA_W-1:0] head;
        head = (sb.size() != 0) ? sb[0] : '0;
        check({tag, ".count"},     32'(count),     32'(sb.size()));
        check({tag, ".in_full"},   32'(in_full),   32'(sb.size() == DEPTH));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
        check({tag, ".out"},       32'(out),       32'(head));
`ifdef DISPLAY_FIFO_OVF_EN
        check({tag, ".ovf"},       32'(ovf),       32'(exp_ovf));
`endif
    endtask

    // One clock of stimulus; the model decides push/pop/drop before the edge.
    task automatic step(input string tag, input logic en, input logic [15:0] data,
                        input logic rdy, input logic clr);
        logic full_before;
        logic pop;
        logic drop;
        logic [DATA_W-1:0] exp_head;
        full_before = (sb.size() == DEPTH);
        pop         = (sb.size() != 0) && rdy;
        drop        = en && full_before && !pop;
        if (pop) begin
            exp_head = sb.pop_front();
            check({tag, ".pop_data"}, 32'(out), 32'(exp_head));
        end
        if (en && (!full_before || pop)) begin
            sb.push_back(data[DATA_W-1:0]);
        end
        exp_ovf   = drop ? 1'b1 : (clr ? 1'b0 : exp_ovf);
        in_en     = en;
        din       = data;
        out_ready = rdy;
        ovf_clr   = clr;
        @(posedge clk);
        #1;
        in_en     = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        check_state(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_en     = 1'b0;
        din       = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        #1;
        check_state("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_state("post_reset");

        // Single write falls through to the output on the next cycle.
        step("wr1241", 1'b1, 16'h1241, 1'b0, 1'b0);
        step("drain41", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Fill, drop a write while full, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            step("fill", 1'b1, 16'(i), 1'b0, 1'b0);
        end
        step("drop_full", 1'b1, 16'h0066, 1'b0, 1'b0);
        step("idle_full", 1'b0, 16'h0000, 1'b0, 1'b0);
        step("ovf_clr", 1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step("drain", 1'b0, 16'h0000, 1'b1, 1'b0);
        end
        step("empty_rdy", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Simultaneous push and pop while full.
        for (int i = 1; i <= 4; i++) begin
            step("refill", 1'b1, 16'(i), 1'b0, 1'b0);
        end
        step("full_pushpop", 1'b1, 16'h0005, 1'b1, 1'b0);
        // Drop coinciding with clear leaves the flag set.
        step("drop_vs_clr", 1'b1, 16'h0099, 1'b0, 1'b1);
        step("ovf_clr2", 1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step("drain2", 1'b0, 16'h0000, 1'b1, 1'b0);
        end

        // Push and ready together on an empty buffer: push only.
        step("empty_pushpop", 1'b1, 16'h0077, 1'b1, 1'b0);
        step("wr_a", 1'b1, 16'hFF12, 1'b0, 1'b0);
        step("wr_b", 1'b1, 16'h0034, 1'b0, 1'b0);

        // Asynchronous reset with three entries buffered.
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        exp_ovf = 1'b0;
        check_state("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("first_after_rst", 1'b1, 16'hAB5A, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 2) == 0),
`ifdef DISPLAY_FIFO_OVF_EN
                 1'($urandom_range(0, 3) == 0)
`else
                 1'b0
`endif
                 );
        end
        for (int i = 0; i < DEPTH; i++) begin
            step("final_drain", 1'b0, 16'h0000, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_display_fifo

`default_nettype wire
